// File: rtl/mux4w_rr.sv
// mux4w_rr: four-source round-robin merge into one registered, source-tagged output stream
module mux4w_rr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr;
  logic [3:0]       rot;
  logic [1:0]       gidx;
  logic             any, load_en, xfer;
  logic [WIDTH-1:0] sel_data;

  // rotate valids so the pointer position becomes bit 0, pick first set bit, map back to a source index
  always_comb begin
    rot      = 4'({in_valid, in_valid} >> ptr);
    any      = |in_valid;
    gidx     = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    sel_data = gidx == 2'd0 ? in_data0 : gidx == 2'd1 ? in_data1 : gidx == 2'd2 ? in_data2 : in_data3;
  end

  // holder next state and handshake; ready is masked while reset is asserted
  always_comb begin
    state_d  = state_q;
    load_en  = state_q == EMPTY || out_ready;
    xfer     = load_en && any;
    in_ready = (rst_n && xfer) ? 4'b0001 << gidx : 4'b0000;
    if (load_en) state_d = any ? FULL : EMPTY;
  end

  // holder state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // capture the granted word and advance the pointer past the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= 2'd0;
      ptr      <= 2'd0;
    end else if (xfer) begin
      out_data <= sel_data;
      out_sel  <= gidx;
      ptr      <= gidx + 2'd1;
    end
  end

  assign out_valid = state_q == FULL;
endmodule
